round_robin_scheduler: RTL and testbench
========================================

// Module: round_robin_scheduler
// PURPOSE
// - Time-slice scheduler for the multiprogrammed PC: tracks up to NUM_PROG user programs, their saved PCs and ready flags.
// - Counts retired instructions against a quantum. Preempts to the OS at ADDR OS_ENTRY and picks the next ready program round-robin.
// - Supplies the PC with program base offset and resume address. Sits between the control unit and the PC.
// PARAMETERS
// - NUM_PROG     5     number of user program slots (ids 1..NUM_PROG; id 0 = OS)
// - QUANTUM      5     instructions per time slice
// - PROG_STRIDE  1000  base offset = id*PROG_STRIDE
// - OS_ENTRY     0     OS entry address on preemption
// PORTS
// - clock          in   1   single clock, posedge
// - reset          in   1   synchronous, active-low
// - stop           in   1   freeze: no state, counter or output change except reset
// - inst_retire    in   1   one user-program instruction completed this cycle
// - end_program    in   1   current program executed its halt
// - branch_pend    in   1   PC is taking a branch this cycle (desvio!=0); preemption deferred
// - pc_current     in   32  PC value of the last retired instruction
// - load_en        in   1   OS registers a program: ready[load_id]=1, saved_pc=load_pc
// - load_id        in   3   slot being loaded (1..NUM_PROG; others ignored)
// - load_pc        in   32  start address (relative, no offset)
// - dispatch_req   in   1   OS asks to resume the next user program
// - active_prog    out  3   id currently owning the PC (0 = OS)
// - base_offset    out  32  active_prog*PROG_STRIDE
// - jump_en        out  1   1-cycle pulse: PC must load jump_addr
// - jump_addr      out  32  absolute target (OS_ENTRY or saved_pc+offset)
// - all_done       out  1   no slot ready and OS idle
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=OS, active_prog=0, base_offset=0, jump_en=0, jump_addr=0, all ready=0, saved_pc=0, quantum cnt=0, last=0, all_done=1.
// - FSM: OS -> PICK -> DISPATCH -> RUN -> SAVE -> OS.
//   OS: dispatch_req & any ready -> PICK; dispatch_req & none ready -> stay, all_done=1.
//   PICK (1 cycle): next = first ready id after `last`, wrapping NUM_PROG->1.
//   DISPATCH (1 cycle): jump_en=1, jump_addr=saved_pc[next]+next*PROG_STRIDE, active_prog=next, cnt=0 -> RUN.
//   RUN: inst_retire increments cnt (saturates at QUANTUM). end_program -> ready[id]=0 -> SAVE.
//     cnt>=QUANTUM & !branch_pend -> saved_pc[id]=pc_current+1-base_offset -> SAVE.
//     Expiry while branch_pend=1 is held until the first cycle with branch_pend=0.
//   SAVE (1 cycle): jump_en=1, jump_addr=OS_ENTRY, active_prog=0, base_offset=0, last=id -> OS.
// - Latency: dispatch_req to jump_en = 2 cycles; quantum expiry to jump_en = 1 cycle.
// - Simultaneous end_program & expiry: end wins, slot becomes not ready, nothing saved.
// - load_en in any state is accepted. Loading the running slot updates saved_pc only, never the live program.
// - Single ready slot: PICK reselects the same id.
// - Arithmetic: 32-bit unsigned, wrap modulo 2^32; id*PROG_STRIDE computed combinationally, no multiplier state.
// - stop high: all regs hold, jump_en forced 0; a pending pulse is re-issued when stop falls.
// - Reset mid-RUN: program is lost, scheduler returns to OS with no jump pulse.
// CONFIGURATION
// - SCHED_STATS_EN defined: per-slot 32-bit retired-instruction counters (cleared by reset and load_en) plus slice counters.
//   Adds ports stat_sel[2:0] in and stat_count[31:0] out (combinational read).
// - Undefined: no counters, no stat ports; behaviour otherwise identical.
// STRUCTURE
// - sched_pkg: state enum {S_OS,S_PICK,S_DISPATCH,S_RUN,S_SAVE}, PROG_ID_W=3, OS_ID=0.
// - Sub-module rr_picker: combinational ready-vector + last -> next id, found flag.
// - Context table (ready bits, saved_pc array) stays in this module.
// TESTING
// - Load slots 1,2 (pc 0,10); dispatch; 5 retires -> SAVE, jump_addr=0; dispatch -> jump_addr=2010.
// - Expiry with branch_pend=1 for 3 cycles -> jump_en only in cycle after branch_pend drops.
// - end_program same cycle as 5th retire -> slot 1 not ready, next dispatch goes to slot 2 only.
// - Only slot 5 ready, last=5 -> wrap picks 5, jump_addr=5000+saved_pc.
// - No slot ready + dispatch_req -> stays OS, all_done=1, no jump_en.
// - reset low during RUN -> next cycle active_prog=0, all ready cleared; stop high holds cnt and pulses.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and constants for the round-robin program scheduler.
package sched_pkg;

    typedef enum logic [2:0] {
        S_OS,
        S_PICK,
        S_DISPATCH,
        S_RUN,
        S_SAVE
    } sched_state_e;

    localparam int unsigned         PROG_ID_W = 3;
    localparam logic [PROG_ID_W-1:0] OS_ID    = '0;

    // Absolute base address of a program slot; combinational, wraps modulo 2^32.
    function automatic logic [31:0] prog_base(input logic [PROG_ID_W-1:0] id,
                                              input int unsigned           stride);
        return 32'(id) * stride;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first ready slot strictly after i_last, wrapping
// NUM_PROG -> 1; i_last itself is the final candidate so a single ready slot
// is reselected.
module rr_picker
    import sched_pkg::*;
#(
    parameter int unsigned NUM_PROG = 5
) (
    input  logic [NUM_PROG:1]    i_ready,
    input  logic [PROG_ID_W-1:0] i_last,
    output logic [PROG_ID_W-1:0] o_next,
    output logic                 o_found
);

    int unsigned w_cand;

    // Scan candidates in round-robin order and keep the first ready one.
    always_comb begin
        o_next  = OS_ID;
        o_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= NUM_PROG; k++) begin
            w_cand = ((32'(i_last) + k - 1) % NUM_PROG) + 1;
            if (!o_found && i_ready[PROG_ID_W'(w_cand)]) begin
                o_found = 1'b1;
                o_next  = PROG_ID_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/round_robin_scheduler.sv
// Time-slice scheduler between control unit and PC: keeps the context table
// (ready bits, saved PCs), counts retired instructions per quantum, preempts
// to the OS entry and dispatches the next ready program round-robin.
// Optional build macro SCHED_STATS_EN adds retired-instruction and slice
// counters with a stat_sel / stat_count read port.
module round_robin_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_PROG    = 5,
    parameter int unsigned QUANTUM     = 5,
    parameter int unsigned PROG_STRIDE = 1000,
    parameter int unsigned OS_ENTRY    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stop,
    input  logic                 inst_retire,
    input  logic                 end_program,
    input  logic                 branch_pend,
    input  logic [31:0]          pc_current,
    input  logic                 load_en,
    input  logic [PROG_ID_W-1:0] load_id,
    input  logic [31:0]          load_pc,
    input  logic                 dispatch_req,
    output logic [PROG_ID_W-1:0] active_prog,
    output logic [31:0]          base_offset,
    output logic                 jump_en,
    output logic [31:0]          jump_addr,
    output logic                 all_done
`ifdef SCHED_STATS_EN
    ,
    input  logic [2:0]           stat_sel,
    output logic [31:0]          stat_count
`endif
);

    localparam int unsigned       CNT_W = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0]  Q_LIM = CNT_W'(QUANTUM);

    sched_state_e          r_state;
    sched_state_e          w_state_next;
    logic [NUM_PROG:1]     r_ready;
    logic [31:0]           r_saved_pc [1:NUM_PROG];
    logic [PROG_ID_W-1:0]  r_active;
    logic [PROG_ID_W-1:0]  r_last;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_jump_addr;

    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_expire;
    logic                  w_any_ready;
    logic                  w_load_ok;
    logic [PROG_ID_W-1:0]  w_pick_id;
    logic                  w_pick_found;

    assign w_any_ready = |r_ready;
    assign w_load_ok   = load_en && (load_id != OS_ID) && (32'(load_id) <= NUM_PROG);
    assign w_cnt_next  = (inst_retire && (r_cnt < Q_LIM)) ? r_cnt + 1'b1 : r_cnt;
    assign w_expire    = (w_cnt_next >= Q_LIM) && !branch_pend;

    rr_picker #(
        .NUM_PROG (NUM_PROG)
    ) u_picker (
        .i_ready (r_ready),
        .i_last  (r_last),
        .o_next  (w_pick_id),
        .o_found (w_pick_found)
    );

    // State register; stop freezes the FSM, reset overrides stop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_OS;
        end else if (!stop) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_OS:       if (dispatch_req && w_any_ready) w_state_next = S_PICK;
            S_PICK:     w_state_next = w_pick_found ? S_DISPATCH : S_OS;
            S_DISPATCH: w_state_next = S_RUN;
            S_RUN:      if (end_program || w_expire) w_state_next = S_SAVE;
            S_SAVE:     w_state_next = S_OS;
            default:    w_state_next = S_OS;
        endcase
    end

    // Context table, quantum counter and jump target; active_prog and the
    // jump target are set on entry to DISPATCH/SAVE so they are valid during
    // the pulse cycle. A load is applied last so it wins over a same-cycle save.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ready     <= '0;
            r_active    <= OS_ID;
            r_last      <= OS_ID;
            r_cnt       <= '0;
            r_jump_addr <= '0;
            for (int unsigned i = 1; i <= NUM_PROG; i++) begin
                r_saved_pc[i] <= '0;
            end
        end else if (!stop) begin
            case (r_state)
                S_PICK: begin
                    if (w_pick_found) begin
                        r_active    <= w_pick_id;
                        r_cnt       <= '0;
                        r_jump_addr <= r_saved_pc[w_pick_id] + prog_base(w_pick_id, PROG_STRIDE);
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (end_program || w_expire) begin
                        if (end_program) begin
                            r_ready[r_active] <= 1'b0;
                        end else begin
                            r_saved_pc[r_active] <= pc_current + 32'd1 - base_offset;
                        end
                        r_last      <= r_active;
                        r_active    <= OS_ID;
                        r_jump_addr <= OS_ENTRY;
                    end
                end
                default: ;
            endcase
            if (w_load_ok) begin
                r_ready[load_id]    <= 1'b1;
                r_saved_pc[load_id] <= load_pc;
            end
        end
    end

    assign active_prog = r_active;
    assign base_offset = prog_base(r_active, PROG_STRIDE);
    assign jump_addr   = r_jump_addr;
    // Pulse is derived from the held state, so it reappears when stop falls.
    assign jump_en     = ((r_state == S_DISPATCH) || (r_state == S_SAVE)) && !stop;
    assign all_done    = (r_state == S_OS) && !w_any_ready;

`ifdef SCHED_STATS_EN
    logic [31:0] r_retired [1:NUM_PROG];
    logic [31:0] r_slices;

    // Per-slot retired-instruction counters and total dispatched slices.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_slices <= '0;
            for (int unsigned i = 1; i <= NUM_PROG; i++) begin
                r_retired[i] <= '0;
            end
        end else if (!stop) begin
            if (r_state == S_DISPATCH) begin
                r_slices <= r_slices + 32'd1;
            end
            if ((r_state == S_RUN) && inst_retire) begin
                r_retired[r_active] <= r_retired[r_active] + 32'd1;
            end
            if (w_load_ok) begin
                r_retired[load_id] <= '0;
            end
        end
    end

    // Combinational read: 0 selects slice count, 1..NUM_PROG a slot counter.
    always_comb begin
        stat_count = '0;
        if (stat_sel == 3'd0) begin
            stat_count = r_slices;
        end else if (32'(stat_sel) <= NUM_PROG) begin
            stat_count = r_retired[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Self-checking bench for round_robin_scheduler (default build).
module tb_round_robin_scheduler;

    logic        clock = 1'b0;
    logic        reset, stop, inst_retire, end_program, branch_pend;
    logic [31:0] pc_current;
    logic        load_en;
    logic [2:0]  load_id;
    logic [31:0] load_pc;
    logic        dispatch_req;
    logic [2:0]  active_prog;
    logic [31:0] base_offset;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        all_done;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Transaction-level model of the context table.
    bit          m_ready [1:5];
    int unsigned m_saved [1:5];
    int unsigned m_last;
    int unsigned m_cur;
    int unsigned m_cnt;

    round_robin_scheduler #(
        .NUM_PROG(5), .QUANTUM(5), .PROG_STRIDE(1000), .OS_ENTRY(0)
    ) dut (
        .clock(clock), .reset(reset), .stop(stop), .inst_retire(inst_retire),
        .end_program(end_program), .branch_pend(branch_pend), .pc_current(pc_current),
        .load_en(load_en), .load_id(load_id), .load_pc(load_pc),
        .dispatch_req(dispatch_req), .active_prog(active_prog), .base_offset(base_offset),
        .jump_en(jump_en), .jump_addr(jump_addr), .all_done(all_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit none_ready();
        for (int i = 1; i <= 5; i++) if (m_ready[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Walk forward from the last-run slot, wrapping 5 -> 1, back to itself.
    function automatic int unsigned model_pick();
        int unsigned id = m_last;
        repeat (5) begin
            id = (id >= 5) ? 1 : id + 1;
            if (m_ready[id]) return id;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 1; i <= 5; i++) begin m_ready[i] = 0; m_saved[i] = 0; end
        m_last = 0; m_cur = 0; m_cnt = 0;
    endfunction

    task automatic do_load(input int unsigned id, input int unsigned pc);
        load_en = 1'b1; load_id = 3'(id); load_pc = pc;
        tick();
        load_en = 1'b0;
        if (id >= 1 && id <= 5) begin m_ready[id] = 1; m_saved[id] = pc; end
    endtask

    task automatic dispatch_chk();
        int unsigned id;
        dispatch_req = 1'b1;
        tick();
        dispatch_req = 1'b0;
        chk("pick_no_pulse", 32'(jump_en), 0);
        tick();
        id = model_pick();
        chk("disp_pulse", 32'(jump_en), 1);
        chk("disp_addr", jump_addr, m_saved[id] + id * 1000);
        chk("disp_active", 32'(active_prog), id);
        chk("disp_base", base_offset, id * 1000);
        m_cur = id; m_cnt = 0;
        tick();
        chk("run_pulse_clear", 32'(jump_en), 0);
    endtask

    // One RUN-state cycle; expiry after QUANTUM retires unless a branch is pending.
    task automatic run_cycle(input bit ret, input bit endp, input bit bp, input bit stp,
                             input int unsigned rel, output bit done);
        bit exp_save = 1'b0;
        inst_retire = ret; end_program = endp; branch_pend = bp; stop = stp;
        pc_current  = m_cur * 1000 + rel;
        if (!stp) begin
            if (ret) m_cnt++;
            exp_save = endp || (m_cnt >= 5 && !bp);
        end
        tick();
        inst_retire = 1'b0; end_program = 1'b0; branch_pend = 1'b0; stop = 1'b0;
        done = exp_save;
        if (exp_save) begin
            if (endp) m_ready[m_cur] = 0;
            else      m_saved[m_cur] = rel + 1;
            m_last = m_cur; m_cur = 0;
            chk("save_pulse", 32'(jump_en), 1);
            chk("save_addr", jump_addr, 0);
            chk("save_active", 32'(active_prog), 0);
            chk("save_base", base_offset, 0);
            tick();
            chk("os_no_pulse", 32'(jump_en), 0);
            chk("os_all_done", 32'(all_done), 32'(none_ready()));
        end else begin
            chk("run_no_pulse", 32'(jump_en), 0);
            chk("run_active", 32'(active_prog), m_cur);
            chk("run_base", base_offset, m_cur * 1000);
        end
    endtask

    task automatic retires(input int unsigned n, input bit end_last);
        bit d;
        for (int unsigned i = 0; i < n; i++)
            run_cycle(1'b1, end_last && (i == n - 1), 1'b0, 1'b0, 100 + i, d);
    endtask

    initial begin
        bit d;
        reset = 0; stop = 0; inst_retire = 0; end_program = 0; branch_pend = 0;
        pc_current = 0; load_en = 0; load_id = 0; load_pc = 0; dispatch_req = 0;
        model_reset();
        tick(); tick();
        chk("rst_active", 32'(active_prog), 0);
        chk("rst_base", base_offset, 0);
        chk("rst_jump_en", 32'(jump_en), 0);
        chk("rst_jump_addr", jump_addr, 0);
        chk("rst_all_done", 32'(all_done), 1);
        reset = 1;
        tick();

        // Two slots, full quantum, then second slot resumes at 2010.
        do_load(1, 0);
        do_load(2, 10);
        chk("loaded_not_done", 32'(all_done), 0);
        dispatch_chk();
        for (int unsigned i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, i, d);
        dispatch_chk();
        chk("slot2_addr_2010", jump_addr, 2010);

        // Expiry held by branch_pend for three cycles.
        for (int unsigned i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 20 + i, d);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 24, d);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 25, d);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 26, d);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 77, d);
        chk("bp_release_save", 32'(d), 1);

        // end_program on 5th retire retires slot 1; slot 2 is reselected alone.
        dispatch_chk();
        retires(5, 1'b1);
        dispatch_chk();
        retires(5, 1'b0);
        dispatch_chk();
        retires(1, 1'b1);

        // Only slot 5 ready; wrap after last=5 reselects it.
        do_load(5, 33);
        dispatch_chk();
        chk("slot5_first", jump_addr, 5033);
        retires(5, 1'b0);
        dispatch_chk();
        chk("slot5_wrap", 32'(active_prog), 5);
        retires(2, 1'b1);

        // Nothing ready: dispatch_req is ignored.
        dispatch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_no_pulse", 32'(jump_en), 0);
            chk("idle_active", 32'(active_prog), 0);
            chk("idle_all_done", 32'(all_done), 1);
        end
        dispatch_req = 1'b0;

        // Reset during RUN drops the program with no pulse.
        do_load(3, 7);
        dispatch_chk();
        retires(2, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        chk("midrst_active", 32'(active_prog), 0);
        chk("midrst_jump_en", 32'(jump_en), 0);
        chk("midrst_all_done", 32'(all_done), 1);
        tick();
        chk("midrst_quiet", 32'(jump_en), 0);

        // stop suppresses and then re-issues the dispatch pulse, and holds cnt.
        do_load(1, 0);
        dispatch_req = 1'b1;
        tick();
        dispatch_req = 1'b0;
        tick();
        chk("stop_pre_pulse", 32'(jump_en), 1);
        stop = 1'b1;
        #1;
        chk("stop_masks_pulse", 32'(jump_en), 0);
        tick(); tick();
        chk("stop_hold_pulse", 32'(jump_en), 0);
        chk("stop_hold_active", 32'(active_prog), 1);
        stop = 1'b0;
        #1;
        chk("stop_reissue", 32'(jump_en), 1);
        chk("stop_reissue_addr", jump_addr, 1000);
        tick();
        m_cur = 1; m_cnt = 0;
        for (int unsigned i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, i, d);
        for (int unsigned i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 50, d);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 9, d);
        chk("stop_cnt_held_save", 32'(d), 1);

        // Randomized slices, including loads to out-of-range ids.
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, 7), $urandom_range(0, 500));
            if (none_ready()) do_load($urandom_range(1, 5), $urandom_range(0, 500));
            dispatch_chk();
            d = 1'b0;
            for (int c = 0; c < 60 && !d; c++)
                run_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 900), d);
            chk("slice_bound", 32'(d), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
